// File: rtl/key_input_pkg.sv
// Shared types and default timing for the key input path.
//   key_state_t : per-channel repeat FSM state encoding
//   default_*   : 10 ms / 500 ms / 100 ms expressed in clocks at clk_mhz
package key_input_pkg;

   localparam int unsigned clk_mhz = 27;
   localparam int unsigned cycles_per_ms = clk_mhz * 1000;

   localparam int unsigned default_debounce_cycles      = cycles_per_ms * 10;
   localparam int unsigned default_repeat_delay_cycles  = cycles_per_ms * 500;
   localparam int unsigned default_repeat_period_cycles = cycles_per_ms * 100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } key_state_t;

endpackage

// File: rtl/key_debounce_repeat_if.sv
// Bundle of raw key inputs and the cleaned-up per-key level/event outputs.
//   master : key source / event consumer (drives key_raw)
//   slave  : the debounce block (drives level, press, release, strobe, held)
interface key_debounce_repeat_if #(
   parameter int unsigned w_key = 8
);

   logic [w_key-1:0] key_raw;
   logic [w_key-1:0] key_level;
   logic [w_key-1:0] key_press;
   logic [w_key-1:0] key_release;
   logic [w_key-1:0] key_strobe;
   logic [w_key-1:0] key_held;

   modport master (
      output key_raw,
      input  key_level, key_press, key_release, key_strobe, key_held
   );

   modport slave (
      input  key_raw,
      output key_level, key_press, key_release, key_strobe, key_held
   );

endinterface

// File: rtl/key_debounce_repeat_channel.sv
// One key: 2-flop synchroniser, debounce counter, press/release pulses and
// typematic repeat FSM.
//   clock, reset : system clock, async active-high reset
//   key_raw      : raw asynchronous key level (1 = pressed)
//   key_level    : debounced level
//   key_press    : 1-cycle pulse on debounced rise
//   key_release  : 1-cycle pulse on debounced fall
//   key_strobe   : 1-cycle pulse on press and on each auto-repeat tick
//   key_held     : high while in REPEAT
module key_channel
   import key_input_pkg::*;
#(
   parameter int unsigned debounce_cycles      = default_debounce_cycles,
   parameter int unsigned repeat_delay_cycles  = default_repeat_delay_cycles,
   parameter int unsigned repeat_period_cycles = default_repeat_period_cycles
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_strobe,
   output logic key_held
);

   localparam int unsigned db_w = $clog2(debounce_cycles + 1);
   localparam int unsigned dl_w = $clog2(repeat_delay_cycles + 1);
   localparam int unsigned pr_w = $clog2(repeat_period_cycles + 1);
   localparam int unsigned rc_w = (dl_w > pr_w) ? dl_w : pr_w;

   localparam logic [db_w-1:0] db_last = db_w'(debounce_cycles - 1);
   localparam logic [rc_w-1:0] dl_last = rc_w'(repeat_delay_cycles - 1);
   localparam logic [rc_w-1:0] pr_last = rc_w'(repeat_period_cycles - 1);

   localparam logic [1:0] s_idle   = 2'(IDLE);
   localparam logic [1:0] s_delay  = 2'(DELAY);
   localparam logic [1:0] s_repeat = 2'(REPEAT);

   logic            sync_a, sync_b;
   logic [db_w-1:0] db_cnt;
   logic            differ, flip, rise, fall;
   logic [1:0]      state, state_next;
   logic [rc_w-1:0] rpt_cnt, rpt_cnt_next;
   logic            strobe_next;

   // Two-flop synchroniser for the asynchronous key input
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= key_raw;
         sync_b <= sync_a;
      end
   end

   // The stable level flips on the debounce_cycles-th consecutive differing cycle
   assign differ = sync_b ^ key_level;
   assign flip   = differ && (db_cnt == db_last);
   assign rise   = flip && sync_b;
   assign fall   = flip && !sync_b;

   // Debounce counter, stable level and edge pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         db_cnt      <= '0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= rise;
         key_release <= fall;
         if (!differ || flip) db_cnt <= '0;
         else                 db_cnt <= db_cnt + db_w'(1);
         if (flip) key_level <= sync_b;
      end
   end

   // Repeat FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= s_idle;
         rpt_cnt    <= '0;
         key_strobe <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         state      <= state_next;
         rpt_cnt    <= rpt_cnt_next;
         key_strobe <= strobe_next;
         key_held   <= (state_next == s_repeat);
      end
   end

   // Repeat FSM next state; a release always beats a repeat tick
   always_comb begin
      state_next   = state;
      rpt_cnt_next = rpt_cnt;
      strobe_next  = 1'b0;
      case (state)
         s_idle: begin
            if (rise) begin
               state_next   = s_delay;
               rpt_cnt_next = '0;
               strobe_next  = 1'b1;
            end
         end
         s_delay: begin
            if (fall) begin
               state_next   = s_idle;
               rpt_cnt_next = '0;
            end else if (rpt_cnt == dl_last) begin
               state_next   = s_repeat;
               rpt_cnt_next = '0;
               strobe_next  = 1'b1;
            end else begin
               rpt_cnt_next = rpt_cnt + rc_w'(1);
            end
         end
         s_repeat: begin
            if (fall) begin
               state_next   = s_idle;
               rpt_cnt_next = '0;
            end else if (rpt_cnt == pr_last) begin
               rpt_cnt_next = '0;
               strobe_next  = 1'b1;
            end else begin
               rpt_cnt_next = rpt_cnt + rc_w'(1);
            end
         end
         default: begin
            state_next   = s_idle;
            rpt_cnt_next = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce_repeat.sv
// Debounce and typematic repeat for w_key independent board keys.
//   clock, reset : system clock, async active-high reset
//   keys         : key_raw in; key_level/press/release/strobe/held out
module key_debounce_repeat
   import key_input_pkg::*;
#(
   parameter int unsigned w_key                = 8,
   parameter int unsigned debounce_cycles      = default_debounce_cycles,
   parameter int unsigned repeat_delay_cycles  = default_repeat_delay_cycles,
   parameter int unsigned repeat_period_cycles = default_repeat_period_cycles
) (
   input logic                   clock,
   input logic                   reset,
   key_debounce_repeat_if.slave  keys
);

   // One fully independent channel per key
   for (genvar i = 0; i < w_key; i++) begin : g_ch
      key_channel #(
         .debounce_cycles      (debounce_cycles),
         .repeat_delay_cycles  (repeat_delay_cycles),
         .repeat_period_cycles (repeat_period_cycles)
      ) u_ch (
         .clock       (clock),
         .reset       (reset),
         .key_raw     (keys.key_raw[i]),
         .key_level   (keys.key_level[i]),
         .key_press   (keys.key_press[i]),
         .key_release (keys.key_release[i]),
         .key_strobe  (keys.key_strobe[i]),
         .key_held    (keys.key_held[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Self-checking bench: expected pulse events (cycle, channel, kind) are queued
// when stimulus is applied and matched in order against observed pulses.
module tb_key_debounce_repeat;

   localparam int unsigned w_key = 8;
   localparam int unsigned db    = 4;
   localparam int unsigned rd    = 20;
   localparam int unsigned rp    = 5;
   localparam int unsigned lat   = 2 + db;

   localparam logic [15:0] k_press   = 16'd1;
   localparam logic [15:0] k_release = 16'd2;
   localparam logic [15:0] k_strobe  = 16'd3;

   logic clock = 1'b0;
   logic reset = 1'b1;

   key_debounce_repeat_if #(.w_key(w_key)) kif ();

   key_debounce_repeat #(
      .w_key                (w_key),
      .debounce_cycles      (db),
      .repeat_delay_cycles  (rd),
      .repeat_period_cycles (rp)
   ) dut (
      .clock (clock),
      .reset (reset),
      .keys  (kif)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   function automatic logic [63:0] ev(input int unsigned c, input int unsigned ch,
                                      input logic [15:0] kind);
      return {32'(c), 16'(ch), kind};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic pulse_of(input int unsigned ch, input int k);
      case (k)
         1:       return kif.key_press[ch];
         2:       return kif.key_release[ch];
         default: return kif.key_strobe[ch];
      endcase
   endfunction

   // Observed pulses, in channel then kind order, must match the queue head
   always @(negedge clock) begin
      for (int ch = 0; ch < w_key; ch++) begin
         for (int k = 1; k <= 3; k++) begin
            if (pulse_of(ch, k) === 1'b1) begin
               if (exp_q.size() == 0)
                  check("unexpected_pulse", ev(cyc, ch, 16'(k)), '1);
               else
                  check("pulse", ev(cyc, ch, 16'(k)), exp_q.pop_front());
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_level"}, 64'(kif.key_level), 64'd0);
      check({tag, "_held"},  64'(kif.key_held),  64'd0);
      check({tag, "_pulses"}, 64'(kif.key_press | kif.key_release | kif.key_strobe), 64'd0);
   endtask

   // Press one key, release raw after 'hold' cycles; queue every expected event
   task automatic press_hold(input int unsigned ch, input int unsigned hold);
      int unsigned c, p, rel;
      logic exp_lvl, exp_held;
      c   = cyc;
      p   = c + lat;
      rel = c + hold + lat;
      exp_q.push_back(ev(p, ch, k_press));
      exp_q.push_back(ev(p, ch, k_strobe));
      for (int unsigned t = p + rd; t < rel; t += rp)
         exp_q.push_back(ev(t, ch, k_strobe));
      exp_q.push_back(ev(rel, ch, k_release));
      kif.key_raw[ch] = 1'b1;
      while (cyc < rel + 3) begin
         @(negedge clock);
         if (cyc == c + hold) kif.key_raw[ch] = 1'b0;
         exp_lvl  = (cyc >= p) && (cyc < rel);
         exp_held = (cyc >= p + rd) && (cyc < rel);
         check("level", 64'(kif.key_level), exp_lvl  ? (64'd1 << ch) : 64'd0);
         check("held",  64'(kif.key_held),  exp_held ? (64'd1 << ch) : 64'd0);
      end
      check("pending_after_hold", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [4:0]  pat;
      int unsigned c, d;

      kif.key_raw = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;

      // Idle for 50 cycles: nothing may happen
      repeat (50) @(negedge clock);
      check_all_zero("idle");

      // Clean press on key 0, released before the repeat delay
      press_hold(0, 10);

      // Bounce 1,0,1,1,0 then steady 1 on key 0
      pat = 5'b01101;
      for (int i = 0; i < 5; i++) begin
         kif.key_raw[0] = pat[i];
         @(negedge clock);
      end
      press_hold(0, 10);

      // 3-cycle glitch on key 3 never reaches the stable level
      kif.key_raw[3] = 1'b1;
      repeat (3) @(negedge clock);
      kif.key_raw[3] = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         check("glitch_level", 64'(kif.key_level), 64'd0);
      end

      // Long hold on key 1; release lands exactly on a repeat slot (offset 60)
      press_hold(1, lat + 54);

      // Hold on key 1 with raw release at offset 35
      press_hold(1, lat + 35);

      // Keys 2 and 5 together, then reset during DELAY with keys still held
      c = cyc;
      exp_q.push_back(ev(c + lat, 2, k_press));
      exp_q.push_back(ev(c + lat, 2, k_strobe));
      exp_q.push_back(ev(c + lat, 5, k_press));
      exp_q.push_back(ev(c + lat, 5, k_strobe));
      kif.key_raw[2] = 1'b1;
      kif.key_raw[5] = 1'b1;
      repeat (lat + 8) @(negedge clock);
      check("multi_level", 64'(kif.key_level), 64'h24);
      check("multi_held",  64'(kif.key_held),  64'd0);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_all_zero("mid_reset");
      check("pending_before_reset_release", 64'(exp_q.size()), 64'd0);
      reset = 1'b0;
      d = cyc;
      exp_q.push_back(ev(d + lat, 2, k_press));
      exp_q.push_back(ev(d + lat, 2, k_strobe));
      exp_q.push_back(ev(d + lat, 5, k_press));
      exp_q.push_back(ev(d + lat, 5, k_strobe));
      repeat (lat - 1) @(negedge clock);
      check("repress_early_level", 64'(kif.key_level), 64'd0);
      repeat (3) @(negedge clock);
      check("repress_level", 64'(kif.key_level), 64'h24);
      kif.key_raw[2] = 1'b0;
      kif.key_raw[5] = 1'b0;
      exp_q.push_back(ev(cyc + lat, 2, k_release));
      exp_q.push_back(ev(cyc + lat, 5, k_release));
      repeat (lat + 4) @(negedge clock);
      check_all_zero("final");

      check("pending_final", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
